// File: rtl/sc_seqgen_engine_if.sv
// sc_seqgen_engine_if: term stream between the sequence engine and its consumer.
// Ports: master drives data/index/valid and reads ready; slave is the mirror image.
interface sc_seqgen_engine_if #(
   parameter int DATAWIDTH_BUS   = 8,
   parameter int DATAWIDTH_COUNT = 6
);
   logic [DATAWIDTH_BUS-1:0]   SC_SEQGEN_data_OutBUS;
   logic                       SC_SEQGEN_valid_OutHigh;
   logic [DATAWIDTH_COUNT-1:0] SC_SEQGEN_index_OutBUS;
   logic                       SC_SEQGEN_ready_InHigh;

   modport master (
      output SC_SEQGEN_data_OutBUS,
      output SC_SEQGEN_valid_OutHigh,
      output SC_SEQGEN_index_OutBUS,
      input  SC_SEQGEN_ready_InHigh
   );

   modport slave (
      input  SC_SEQGEN_data_OutBUS,
      input  SC_SEQGEN_valid_OutHigh,
      input  SC_SEQGEN_index_OutBUS,
      output SC_SEQGEN_ready_InHigh
   );
endinterface

// File: rtl/sc_seqgen_engine.sv
// sc_seqgen_engine: additive recurrence generator (next = A + B) on a valid/ready stream.
// Ports: clock, async reset, start/abort, mode/seeds/count setup, seqStream term stream,
//        busy, done pulse, sticky overflow flag.
module sc_seqgen_engine #(
   parameter int DATAWIDTH_BUS   = 8,
   parameter int DATAWIDTH_COUNT = 6,
   parameter int DATAWIDTH_MODE  = 2
) (
   input  logic                       SC_SEQGEN_CLOCK_50,
   input  logic                       SC_SEQGEN_RESET_InHigh,
   input  logic                       SC_SEQGEN_start_InHigh,
   input  logic                       SC_SEQGEN_abort_InHigh,
   input  logic [DATAWIDTH_MODE-1:0]  SC_SEQGEN_mode_InBUS,
   input  logic [DATAWIDTH_BUS-1:0]   SC_SEQGEN_seed0_InBUS,
   input  logic [DATAWIDTH_BUS-1:0]   SC_SEQGEN_seed1_InBUS,
   input  logic [DATAWIDTH_COUNT-1:0] SC_SEQGEN_count_InBUS,
   sc_seqgen_engine_if.master         seqStream,
   output logic                       SC_SEQGEN_busy_OutHigh,
   output logic                       SC_SEQGEN_done_OutHigh,
   output logic                       SC_SEQGEN_overflow_OutHigh
);
   typedef enum logic [1:0] {
      STATE_IDLE,
      STATE_EMIT,
      STATE_DONE
   } state_t;

   localparam logic [DATAWIDTH_COUNT:0] COUNT_ONE = 1;

   state_t stateReg;
   state_t stateNext;

   logic [DATAWIDTH_BUS-1:0]   termA;
   logic [DATAWIDTH_BUS-1:0]   termB;
   logic                       termBOvf;
   logic [DATAWIDTH_COUNT-1:0] termIndex;
   logic [DATAWIDTH_COUNT-1:0] termCount;
   logic                       overflowReg;

   logic [DATAWIDTH_BUS:0]     termSum;
   logic [DATAWIDTH_BUS-1:0]   seedA;
   logic [DATAWIDTH_BUS-1:0]   seedB;
   logic                       startAccept;
   logic                       handshake;
   logic                       lastTerm;

   // One extra bit so the MSB is the carry out of A + B.
   assign termSum = {1'b0, termA} + {1'b0, termB};

   // Compared one bit wider so index+1 cannot wrap onto N.
   assign lastTerm = ({1'b0, termIndex} + COUNT_ONE) == {1'b0, termCount};

   assign startAccept = (stateReg == STATE_IDLE) && SC_SEQGEN_start_InHigh
                        && !SC_SEQGEN_abort_InHigh;
   assign handshake   = (stateReg == STATE_EMIT) && seqStream.SC_SEQGEN_ready_InHigh
                        && !SC_SEQGEN_abort_InHigh;

   // Reserved mode falls back to Fibonacci seeds.
   always_comb begin
      seedA = '0;
      seedB = DATAWIDTH_BUS'(1);
      case (SC_SEQGEN_mode_InBUS)
         DATAWIDTH_MODE'(1): begin
            seedA = DATAWIDTH_BUS'(2);
            seedB = DATAWIDTH_BUS'(1);
         end
         DATAWIDTH_MODE'(2): begin
            seedA = SC_SEQGEN_seed0_InBUS;
            seedB = SC_SEQGEN_seed1_InBUS;
         end
         default: ;
      endcase
   end

   always_ff @(posedge SC_SEQGEN_CLOCK_50 or posedge SC_SEQGEN_RESET_InHigh) begin
      if (SC_SEQGEN_RESET_InHigh) begin
         stateReg <= STATE_IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      unique case (stateReg)
         STATE_IDLE: begin
            if (startAccept) begin
               stateNext = (SC_SEQGEN_count_InBUS == '0) ? STATE_DONE : STATE_EMIT;
            end
         end
         STATE_EMIT: begin
            if (SC_SEQGEN_abort_InHigh) begin
               stateNext = STATE_IDLE;
            end else if (handshake && (lastTerm || termBOvf)) begin
               stateNext = STATE_DONE;
            end
         end
         STATE_DONE: stateNext = STATE_IDLE;
         default:    stateNext = STATE_IDLE;
      endcase
   end

   always_comb begin
      seqStream.SC_SEQGEN_valid_OutHigh = (stateReg == STATE_EMIT);
      SC_SEQGEN_busy_OutHigh            = (stateReg != STATE_IDLE);
      SC_SEQGEN_done_OutHigh            = (stateReg == STATE_DONE);
   end

   // termBOvf marks B itself as unrepresentable, so the run ends
   // before B would ever be presented as a term.
   always_ff @(posedge SC_SEQGEN_CLOCK_50 or posedge SC_SEQGEN_RESET_InHigh) begin
      if (SC_SEQGEN_RESET_InHigh) begin
         termA       <= '0;
         termB       <= '0;
         termBOvf    <= 1'b0;
         termIndex   <= '0;
         termCount   <= '0;
         overflowReg <= 1'b0;
      end else if (startAccept) begin
         termA       <= seedA;
         termB       <= seedB;
         termBOvf    <= 1'b0;
         termIndex   <= '0;
         termCount   <= SC_SEQGEN_count_InBUS;
         overflowReg <= 1'b0;
      end else if (handshake && !lastTerm) begin
         if (termBOvf) begin
            overflowReg <= 1'b1;
         end else begin
            termA     <= termB;
            termB     <= termSum[DATAWIDTH_BUS-1:0];
            termBOvf  <= termSum[DATAWIDTH_BUS];
            termIndex <= termIndex + DATAWIDTH_COUNT'(1);
         end
      end
   end

   assign seqStream.SC_SEQGEN_data_OutBUS  = termA;
   assign seqStream.SC_SEQGEN_index_OutBUS = termIndex;
   assign SC_SEQGEN_overflow_OutHigh       = overflowReg;
endmodule

// File: tb/tb_sc_seqgen_engine.sv
// tb_sc_seqgen_engine: scoreboard bench for sc_seqgen_engine.
// Reference sequence is built from integer recurrence; a monitor pops and compares.
module tb_sc_seqgen_engine;
   localparam int W = 8;
   localparam int C = 6;
   localparam int M = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic [M-1:0] mode;
   logic [W-1:0] seed0;
   logic [W-1:0] seed1;
   logic [C-1:0] count;
   logic         busy;
   logic         done;
   logic         overflow;

   sc_seqgen_engine_if #(.DATAWIDTH_BUS(W), .DATAWIDTH_COUNT(C)) seqStream ();

   sc_seqgen_engine #(
      .DATAWIDTH_BUS(W),
      .DATAWIDTH_COUNT(C),
      .DATAWIDTH_MODE(M)
   ) dut (
      .SC_SEQGEN_CLOCK_50(clk),
      .SC_SEQGEN_RESET_InHigh(rst),
      .SC_SEQGEN_start_InHigh(start),
      .SC_SEQGEN_abort_InHigh(abort),
      .SC_SEQGEN_mode_InBUS(mode),
      .SC_SEQGEN_seed0_InBUS(seed0),
      .SC_SEQGEN_seed1_InBUS(seed1),
      .SC_SEQGEN_count_InBUS(count),
      .seqStream(seqStream),
      .SC_SEQGEN_busy_OutHigh(busy),
      .SC_SEQGEN_done_OutHigh(done),
      .SC_SEQGEN_overflow_OutHigh(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int d;
      int i;
   } term_t;

   term_t expQ[$];
   int checks = 0;
   int passes = 0;
   int doneCnt = 0;
   int accCnt = 0;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic failNow(input string name, input int act, input int exp);
      checks++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: pops expected terms on every handshake and checks hold-while-stalled.
   initial begin
      logic         prevValid;
      logic         prevReady;
      logic [W-1:0] prevData;
      logic [C-1:0] prevIdx;
      term_t        e;
      int           dv;
      int           iv;
      prevValid = 1'b0;
      prevReady = 1'b0;
      prevData  = '0;
      prevIdx   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevValid = 1'b0;
         end else begin
            dv = int'(seqStream.SC_SEQGEN_data_OutBUS);
            iv = int'(seqStream.SC_SEQGEN_index_OutBUS);
            if (prevValid && !prevReady && seqStream.SC_SEQGEN_valid_OutHigh) begin
               check(dv == int'(prevData), "hold_data", dv, int'(prevData));
               check(iv == int'(prevIdx), "hold_index", iv, int'(prevIdx));
            end
            if (seqStream.SC_SEQGEN_valid_OutHigh && seqStream.SC_SEQGEN_ready_InHigh) begin
               if (expQ.size() == 0) begin
                  failNow("unexpected_term", dv, -1);
               end else begin
                  e = expQ.pop_front();
                  check(dv == e.d, "term_data", dv, e.d);
                  check(iv == e.i, "term_index", iv, e.i);
               end
               accCnt++;
            end
            if (done) doneCnt++;
            prevValid = seqStream.SC_SEQGEN_valid_OutHigh;
            prevReady = seqStream.SC_SEQGEN_ready_InHigh;
            prevData  = seqStream.SC_SEQGEN_data_OutBUS;
            prevIdx   = seqStream.SC_SEQGEN_index_OutBUS;
         end
      end
   end

   // Reference: integer recurrence, emit while the term fits in W bits and count < N.
   task automatic buildModel(input int md, input int s0, input int s1, input int n,
                             output bit expOvf);
      int a;
      int b;
      int t;
      int cnt;
      term_t e;
      case (md)
         1:       begin a = 2;  b = 1;  end
         2:       begin a = s0; b = s1; end
         default: begin a = 0;  b = 1;  end
      endcase
      cnt = 0;
      while (cnt < n && a < (1 << W)) begin
         e.d = a;
         e.i = cnt;
         expQ.push_back(e);
         cnt++;
         t = a + b;
         a = b;
         b = t;
      end
      expOvf = (cnt < n);
   endtask

   task automatic issueStart(input int md, input int s0, input int s1, input int n);
      @(posedge clk); #1;
      start = 1'b1;
      mode  = M'(md);
      seed0 = W'(s0);
      seed1 = W'(s1);
      count = C'(n);
      @(posedge clk); #1;
      start = 1'b0;
      mode  = M'($urandom);
      seed0 = W'($urandom);
      seed1 = W'($urandom);
      count = C'($urandom);
   endtask

   // rdyMode: >=100 always ready, <0 toggling, otherwise percent ready.
   task automatic runSeq(input int md, input int s0, input int s1, input int n,
                         input int rdyMode, input string tag);
      bit expOvf;
      int d0;
      int cyc;
      bit rtgl;
      buildModel(md, s0, s1, n, expOvf);
      d0 = doneCnt;
      seqStream.SC_SEQGEN_ready_InHigh = 1'b1;
      issueStart(md, s0, s1, n);
      check(busy == 1'b1, {tag, "_busy_after_start"}, int'(busy), 1);
      check(overflow == 1'b0, {tag, "_ovf_cleared"}, int'(overflow), 0);
      rtgl = 1'b0;
      cyc = 0;
      while (doneCnt == d0 && cyc < 2000) begin
         if (rdyMode < 0) begin
            seqStream.SC_SEQGEN_ready_InHigh = rtgl;
            rtgl = !rtgl;
         end else if (rdyMode >= 100) begin
            seqStream.SC_SEQGEN_ready_InHigh = 1'b1;
         end else begin
            seqStream.SC_SEQGEN_ready_InHigh = ($urandom_range(0, 99) < rdyMode);
         end
         start = ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      seqStream.SC_SEQGEN_ready_InHigh = 1'b0;
      if (doneCnt == d0) failNow({tag, "_timeout"}, cyc, 2000);
      check(overflow == expOvf, {tag, "_overflow"}, int'(overflow), int'(expOvf));
      check(expQ.size() == 0, {tag, "_terms_left"}, expQ.size(), 0);
      check(busy == 1'b0, {tag, "_idle_after_done"}, int'(busy), 0);
      repeat (2) @(posedge clk);
      #1;
      check(doneCnt == d0 + 1, {tag, "_done_pulses"}, doneCnt - d0, 1);
      check(overflow == expOvf, {tag, "_ovf_sticky"}, int'(overflow), int'(expOvf));
      expQ.delete();
   endtask

   task automatic resetTest();
      bit expOvf;
      int a0;
      int cyc;
      buildModel(0, 0, 0, 20, expOvf);
      a0 = accCnt;
      seqStream.SC_SEQGEN_ready_InHigh = 1'b1;
      issueStart(0, 0, 0, 20);
      cyc = 0;
      while (accCnt < a0 + 3 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (accCnt < a0 + 3) failNow("rst_wait_timeout", accCnt - a0, 3);
      #2;
      rst = 1'b1;
      #1;
      check(seqStream.SC_SEQGEN_valid_OutHigh == 1'b0, "rst_mid_valid",
            int'(seqStream.SC_SEQGEN_valid_OutHigh), 0);
      check(busy == 1'b0, "rst_mid_busy", int'(busy), 0);
      check(seqStream.SC_SEQGEN_data_OutBUS == '0, "rst_mid_data",
            int'(seqStream.SC_SEQGEN_data_OutBUS), 0);
      check(seqStream.SC_SEQGEN_index_OutBUS == '0, "rst_mid_index",
            int'(seqStream.SC_SEQGEN_index_OutBUS), 0);
      check(done == 1'b0, "rst_mid_done", int'(done), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      seqStream.SC_SEQGEN_ready_InHigh = 1'b0;
      expQ.delete();
   endtask

   task automatic abortTest();
      term_t e;
      int d0;
      int cyc;
      for (int k = 0; k < 3; k++) begin
         e.d = (k == 0) ? 0 : 1;
         e.i = k;
         expQ.push_back(e);
      end
      d0 = doneCnt;
      seqStream.SC_SEQGEN_ready_InHigh = 1'b1;
      issueStart(0, 0, 0, 20);
      cyc = 0;
      while (!(seqStream.SC_SEQGEN_valid_OutHigh && seqStream.SC_SEQGEN_index_OutBUS == C'(2))
             && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 20) failNow("abort_wait_timeout", cyc, 20);
      abort = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      seqStream.SC_SEQGEN_ready_InHigh = 1'b0;
      check(seqStream.SC_SEQGEN_valid_OutHigh == 1'b0, "abort_valid",
            int'(seqStream.SC_SEQGEN_valid_OutHigh), 0);
      check(busy == 1'b0, "abort_busy", int'(busy), 0);
      check(seqStream.SC_SEQGEN_index_OutBUS == C'(2), "abort_index_held",
            int'(seqStream.SC_SEQGEN_index_OutBUS), 2);
      check(seqStream.SC_SEQGEN_data_OutBUS == W'(1), "abort_data_held",
            int'(seqStream.SC_SEQGEN_data_OutBUS), 1);
      check(overflow == 1'b0, "abort_ovf", int'(overflow), 0);
      repeat (3) @(posedge clk);
      #1;
      check(doneCnt == d0, "abort_no_done", doneCnt - d0, 0);
      check(busy == 1'b0, "abort_start_ignored", int'(busy), 0);
      check(expQ.size() == 0, "abort_terms_left", expQ.size(), 0);
      expQ.delete();
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      mode  = '0;
      seed0 = '0;
      seed1 = '0;
      count = '0;
      seqStream.SC_SEQGEN_ready_InHigh = 1'b0;
      @(posedge clk); #1;
      check(seqStream.SC_SEQGEN_valid_OutHigh == 1'b0, "reset_valid",
            int'(seqStream.SC_SEQGEN_valid_OutHigh), 0);
      check(seqStream.SC_SEQGEN_data_OutBUS == '0, "reset_data",
            int'(seqStream.SC_SEQGEN_data_OutBUS), 0);
      check(seqStream.SC_SEQGEN_index_OutBUS == '0, "reset_index",
            int'(seqStream.SC_SEQGEN_index_OutBUS), 0);
      check(busy == 1'b0, "reset_busy", int'(busy), 0);
      check(done == 1'b0, "reset_done", int'(done), 0);
      check(overflow == 1'b0, "reset_overflow", int'(overflow), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      runSeq(0, 0, 0, 20, 100, "fib20");
      resetTest();
      runSeq(0, 0, 0, 6, 100, "fib6_after_rst");
      runSeq(1, 0, 0, 5, -1, "lucas5");
      runSeq(1, 0, 0, 40, 100, "lucas40");
      runSeq(2, 10, 20, 4, 100, "user4");
      runSeq(2, 10, 20, 1, 60, "user1");
      runSeq(2, 10, 20, 0, 100, "user0");
      runSeq(3, 0, 0, 8, 50, "mode3");
      runSeq(2, 255, 255, 10, 100, "user_max");
      abortTest();
      for (int r = 0; r < 25; r++) begin
         runSeq($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 63), $urandom_range(20, 100), "rand");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
